// File: rtl/seven_segment_pkg.sv
// Shared seven-segment constants (active-low, bit0=a .. bit6=g), reader FSM states
// and the pattern decode function used by the reader.
package seven_segment_pkg;

  localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
  localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
  localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_e;

  typedef enum logic [1:0] {PAT_DIGIT, PAT_BLANK, PAT_INVALID} pat_kind_e;

  typedef struct packed {
    pat_kind_e  kind;
    logic [2:0] number;
  } decode_t;

  function automatic decode_t seg_decode(input logic [6:0] seg);
    decode_t r;
    r.kind   = PAT_DIGIT;
    r.number = 3'd0;
    case (seg)
      SEG_DIGIT_0: r.number = 3'd0;
      SEG_DIGIT_1: r.number = 3'd1;
      SEG_DIGIT_2: r.number = 3'd2;
      SEG_DIGIT_3: r.number = 3'd3;
      SEG_DIGIT_4: r.number = 3'd4;
      SEG_DIGIT_5: r.number = 3'd5;
      SEG_DIGIT_6: r.number = 3'd6;
      SEG_BLANK:   r.kind   = PAT_BLANK;
      default:     r.kind   = PAT_INVALID;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_sync.sv
// Multi-bit flop-chain synchroniser; resets to all-ones so an idle active-low
// segment bus reads as blank.
module seven_segment_sync #(
  parameter int DATA_W = 7,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] sync_q [STAGES];
  logic [DATA_W-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '1;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/seven_segment_reader.sv
// Reads back an active-low 7-segment bus: synchronise, stability-filter, decode.
// Define SEVEN_SEGMENT_READER_ERRCNT_EN to add the err_count/err_clear invalid-pattern counter.
module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hex_in,
  output logic [2:0] number_out,
  output logic       valid,
  output logic       blank,
  output logic       invalid,
  output logic       changed
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  ,
  input  logic       err_clear,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [6:0] s;
  logic [6:0] cand_q, cand_d, prev_q, prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] number_q, number_d;
  logic       valid_q, valid_d, blank_q, blank_d, invalid_q, invalid_d;
  logic       changed_q, changed_d;
  logic       s_diff, accept;
  state_e     state_q, state_d;
  decode_t    dec;

  seven_segment_sync #(.DATA_W(7), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (hex_in),
    .dout (s)
  );

  always_comb begin
    dec    = seg_decode(s);
    s_diff = (s != cand_q);
    cand_d = s;
    if (s_diff)                cnt_d = 8'd1;
    else if (cnt_q < STABLE_N) cnt_d = 8'(cnt_q + 8'd1);
    else                       cnt_d = cnt_q;
    // Accept only on the cycle the count first reaches the target; IDLE ignores a steady blank.
    accept = (cnt_d == STABLE_N) && (s_diff || (cnt_q != STABLE_N))
             && ((state_q != IDLE) || s_diff);

    state_d   = state_q;
    number_d  = number_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    invalid_d = invalid_q;
    prev_d    = prev_q;
    changed_d = 1'b0;

    case (state_q)
      IDLE:    if (s_diff) state_d = SETTLE;
      SETTLE:  state_d = SETTLE;
      LOCKED:  if (s_diff) state_d = SETTLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = LOCKED;
      valid_d   = (dec.kind == PAT_DIGIT);
      blank_d   = (dec.kind == PAT_BLANK);
      invalid_d = (dec.kind == PAT_INVALID);
      if (dec.kind == PAT_DIGIT) number_d = dec.number;
      changed_d = (s != prev_q);
      prev_d    = s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cand_q    <= SEG_BLANK;
      cnt_q     <= 8'd0;
      prev_q    <= SEG_BLANK;
      number_q  <= 3'd0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b1;
      invalid_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      number_q  <= number_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      invalid_q <= invalid_d;
      changed_q <= changed_d;
    end
  end

  assign number_out = number_q;
  assign valid      = valid_q;
  assign blank      = blank_q;
  assign invalid    = invalid_q;
  assign changed    = changed_q;

`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clear)                                         err_d = 8'd0;
    else if (accept && (dec.kind == PAT_INVALID) && (err_q != 8'hFF)) err_d = 8'(err_q + 8'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 8'd0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader: stimulus queues expected output events,
// a monitor pops and compares whenever the outputs move or changed pulses.
`timescale 1ns/100ps
module tb_seven_segment_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] hex_in;
  logic [2:0] number_out;
  logic       valid, blank, invalid, changed;
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  logic       err_clear;
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  seven_segment_reader dut (
    .clk        (clk),
    .rst        (rst),
    .hex_in     (hex_in),
    .number_out (number_out),
    .valid      (valid),
    .blank      (blank),
    .invalid    (invalid),
    .changed    (changed)
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
    ,
    .err_clear  (err_clear),
    .err_count  (err_count)
`endif
  );

  typedef struct {
    logic [2:0] num;
    logic       v, b, i, c;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   spot_req = 0, spot_ack = 0, spot_kind = 0;
  logic mon_en = 1'b0;
  logic [2:0] sp_num;
  logic       sp_v, sp_b, sp_i, sp_c;
  logic [7:0] sp_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sole owner of the counters; serves spot checks and output events.
  initial begin : monitor
    logic [5:0] last, cur;
    exp_t e;
    last = 6'd0;
    forever begin
      @(negedge clk or spot_req);
      cur = {number_out, valid, blank, invalid};
      if (spot_req != spot_ack) begin
        if (spot_kind == 0) begin
          chk("spot number_out", number_out, sp_num);
          chk("spot valid", valid, sp_v);
          chk("spot blank", blank, sp_b);
          chk("spot invalid", invalid, sp_i);
          chk("spot changed", changed, sp_c);
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
          chk("spot err_count", err_count, sp_err);
`endif
        end else begin
          chk("scoreboard drained", q.size(), 0);
        end
        spot_ack = spot_req;
      end else if (mon_en) begin
        if (changed || (cur != last)) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event at cycle %0d: number_out=%0d valid=%0b blank=%0b invalid=%0b changed=%0b, required no change",
                     cyc, number_out, valid, blank, invalid, changed);
          end else begin
            e = q.pop_front();
            chk("event cycle", cyc, e.due);
            chk("event number_out", number_out, e.num);
            chk("event valid", valid, e.v);
            chk("event blank", blank, e.b);
            chk("event invalid", invalid, e.i);
            chk("event changed", changed, e.c);
          end
        end
        last = cur;
      end else begin
        last = cur;
      end
    end
  end

  task automatic spot(input logic [2:0] n, input logic v, b, i, c, input logic [7:0] er);
    sp_num = n; sp_v = v; sp_b = b; sp_i = i; sp_c = c; sp_err = er;
    spot_kind = 0;
    spot_req++;
    wait (spot_ack == spot_req);
  endtask

  task automatic apply(input logic [6:0] hx, input int hold, input bit ev,
                       input logic [2:0] n, input logic v, b, i, c);
    exp_t e;
    @(posedge clk);
    #1;
    hex_in = hx;
    if (ev) begin
      e.num = n; e.v = v; e.b = b; e.i = i; e.c = c;
      e.due = cyc + 6;
      q.push_back(e);
    end
    repeat (hold - 1) @(posedge clk);
  endtask

  logic [6:0] digits [7];

  initial begin : stim
    exp_t e;
    digits[0] = 7'b1000000; digits[1] = 7'b1111001; digits[2] = 7'b0100100;
    digits[3] = 7'b0110000; digits[4] = 7'b0011001; digits[5] = 7'b0010010;
    digits[6] = 7'b0000010;
    rst    = 1'b1;
    hex_in = 7'b1111111;
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
    err_clear = 1'b0;
`endif
    #12;
    spot(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Idle blank bus: no events for 20 cycles.
    repeat (20) @(posedge clk);
    #2;
    spot(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

    apply(7'b0100100, 10, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    // Three-sample glitch to 3 then back to 2: nothing may move.
    apply(7'b0110000, 3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(7'b0100100, 10, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(7'b0000000, 10, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    spot(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
    @(posedge clk); #1; err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
    spot(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
`endif

    for (int k = 0; k < 7; k++) begin
      apply(digits[k], 8, 1'b1, 3'(k), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    apply(7'b1111111, 10, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(7'b0000010, 10, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset pulse in the middle of settling on 5.
    @(posedge clk);
    #1;
    hex_in = 7'b0010010;
    repeat (3) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #0.5;
    spot(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    #0.5;
    rst = 1'b0;
    e.num = 3'd5; e.v = 1'b1; e.b = 1'b0; e.i = 1'b0; e.c = 1'b1;
    e.due = cyc + 6;
    q.push_back(e);
    @(negedge clk);
    #1;
    mon_en = 1'b1;

    repeat (12) @(posedge clk);
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    #2;
    spot_kind = 1;
    spot_req++;
    wait (spot_ack == spot_req);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
